// File: rtl/mux_arb_pkg.sv
// rtl/mux_arb_pkg.sv - shared types and constants for the round-robin mux arbiter
package mux_arb_pkg;
    localparam int NUM_REQ = 4;
    localparam int SEL_W   = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    function automatic logic [NUM_REQ-1:0] onehot(input logic [SEL_W-1:0] i);
        onehot    = '0;
        onehot[i] = 1'b1;
    endfunction
endpackage

// File: rtl/rr_pick4.sv
// rtl/rr_pick4.sv - combinational rotating-priority picker, ptr is highest priority
module rr_pick4
    import mux_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [SEL_W-1:0]   ptr,
    output logic               found,
    output logic [SEL_W-1:0]   idx
);
    logic [SEL_W-1:0] cand;

    // Walk from lowest priority to highest so the nearest request to ptr wins last.
    always_comb begin
        found = 1'b0;
        idx   = ptr;
        cand  = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = ptr + SEL_W'(k);
            if (req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end
endmodule

// File: rtl/mux_4to1_rr_arbiter.sv
// rtl/mux_4to1_rr_arbiter.sv - round-robin arbiter owning a registered 4:1 data mux
module mux_4to1_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int MAX_HOLD = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [NUM_REQ-1:0]   last,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic [WIDTH-1:0]     c,
    input  logic [WIDTH-1:0]     d,
    output logic [SEL_W-1:0]     sel,
    output logic [NUM_REQ-1:0]   gnt,
    output logic [WIDTH-1:0]     out,
    output logic                 out_valid
);
    localparam int HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    state_t               state, state_nxt;
    logic [SEL_W-1:0]     ptr, ptr_nxt, sel_nxt, pick_ptr, pick_idx;
    logic [NUM_REQ-1:0]   gnt_nxt;
    logic [WIDTH-1:0]     out_nxt, data_g;
    logic                 out_valid_nxt, pick_found, beat, rel;
    logic [HOLD_W-1:0]    hold_cnt, hold_nxt;

    always_comb begin
        case (sel)
            2'd0:    data_g = a;
            2'd1:    data_g = b;
            2'd2:    data_g = c;
            default: data_g = d;
        endcase
    end

    // While granted, re-arbitration starts just past the current grantee.
    assign pick_ptr = (state == GRANT) ? (sel + SEL_W'(1)) : ptr;

    rr_pick4 u_pick (
        .req   (req),
        .ptr   (pick_ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    always_comb begin
        state_nxt     = state;
        ptr_nxt       = ptr;
        sel_nxt       = sel;
        gnt_nxt       = gnt;
        out_nxt       = out;
        out_valid_nxt = 1'b0;
        hold_nxt      = hold_cnt;
        beat          = 1'b0;
        rel           = 1'b0;
        case (state)
            IDLE: begin
                gnt_nxt = '0;
                if (pick_found) begin
                    gnt_nxt   = onehot(pick_idx);
                    sel_nxt   = pick_idx;
                    hold_nxt  = '0;
                    state_nxt = GRANT;
                end
            end
            default: begin
                beat = req[sel];
                rel  = !beat || last[sel] || (hold_cnt == HOLD_LAST);
                if (beat) begin
                    out_nxt       = data_g;
                    out_valid_nxt = 1'b1;
                    hold_nxt      = hold_cnt + HOLD_W'(1);
                end
                if (rel) begin
                    ptr_nxt  = sel + SEL_W'(1);
                    hold_nxt = '0;
                    if (pick_found) begin
                        gnt_nxt = onehot(pick_idx);
                        sel_nxt = pick_idx;
                    end else begin
                        gnt_nxt   = '0;
                        state_nxt = IDLE;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            sel       <= '0;
            gnt       <= '0;
            out       <= '0;
            out_valid <= 1'b0;
            hold_cnt  <= '0;
        end else begin
            state     <= state_nxt;
            ptr       <= ptr_nxt;
            sel       <= sel_nxt;
            gnt       <= gnt_nxt;
            out       <= out_nxt;
            out_valid <= out_valid_nxt;
            hold_cnt  <= hold_nxt;
        end
    end
endmodule

// File: tb/tb_mux_4to1_rr_arbiter.sv
// tb/tb_mux_4to1_rr_arbiter.sv - directed self-checking bench for mux_4to1_rr_arbiter
module tb_mux_4to1_rr_arbiter;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req = '0;
    logic [3:0] last = '0;
    logic [3:0] a = '0, b = '0, c = '0, d = '0;
    logic [1:0] sel;
    logic [3:0] gnt;
    logic [3:0] out;
    logic       out_valid;

    int n_checks = 0;
    int n_fails  = 0;

    mux_4to1_rr_arbiter #(.WIDTH(4), .MAX_HOLD(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .last      (last),
        .a         (a),
        .b         (b),
        .c         (c),
        .d         (d),
        .sel       (sel),
        .gnt       (gnt),
        .out       (out),
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [3:0] e_gnt, input logic [1:0] e_sel,
                           input logic [3:0] e_out, input logic e_ov);
        chk({tag, ".gnt"}, 32'(gnt), 32'(e_gnt));
        chk({tag, ".sel"}, 32'(sel), 32'(e_sel));
        chk({tag, ".out"}, 32'(out), 32'(e_out));
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(e_ov));
    endtask

    initial begin
        logic [3:0] rr_gnt [0:4];
        logic [3:0] rr_out [0:4];
        rr_gnt = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
        rr_out = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h1};

        // reset state
        tick(); tick();
        chk_all("reset", 4'b0000, 2'd0, 4'h0, 1'b0);
        rst = 1'b0;

        // single requester c, last on the third beat
        req = 4'b0100; c = 4'hA;
        tick(); chk_all("single.grant", 4'b0100, 2'd2, 4'h0, 1'b0);
        tick(); chk_all("single.beat1", 4'b0100, 2'd2, 4'hA, 1'b1);
        tick(); chk_all("single.beat2", 4'b0100, 2'd2, 4'hA, 1'b1);
        last = 4'b0100;
        tick(); chk_all("single.beat3", 4'b0100, 2'd2, 4'hA, 1'b1);
        req = 4'b0000; last = 4'b0000; c = 4'h5;
        tick(); chk_all("single.release", 4'b0000, 2'd2, 4'hA, 1'b0);

        // idle hold: sel and out keep their values
        for (int i = 0; i < 3; i++) begin
            tick(); chk_all("idle.hold", 4'b0000, 2'd2, 4'hA, 1'b0);
        end

        // ptr is now 3, so d beats a
        req = 4'b1001;
        tick(); chk_all("ptr3.pick", 4'b1000, 2'd3, 4'hA, 1'b0);
        req = 4'b0000;
        tick(); chk_all("ptr3.drop", 4'b0000, 2'd3, 4'hA, 1'b0);

        // round robin, one beat each with no idle cycles
        req = 4'b1111; last = 4'b1111;
        a = 4'h1; b = 4'h2; c = 4'h3; d = 4'h4;
        tick(); chk_all("rr.first", 4'b0001, 2'd0, 4'hA, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("rr.gnt", 32'(gnt), 32'(rr_gnt[i]));
            chk("rr.out", 32'(out), 32'(rr_out[i]));
            chk("rr.out_valid", 32'(out_valid), 32'd1);
        end
        req = 4'b0000; last = 4'b0000;
        tick(); chk_all("rr.stop", 4'b0000, 2'd1, 4'h1, 1'b0);

        // timeout: ptr is 2, scan 2,3,0 picks a
        req = 4'b0011; a = 4'h5; b = 4'h6;
        tick(); chk_all("to.grant_a", 4'b0001, 2'd0, 4'h1, 1'b0);
        for (int i = 1; i <= 8; i++) begin
            tick();
            chk("to.a.out", 32'(out), 32'h5);
            chk("to.a.out_valid", 32'(out_valid), 32'd1);
            chk("to.a.gnt", 32'(gnt), (i < 8) ? 32'b0001 : 32'b0010);
        end
        for (int i = 1; i <= 8; i++) begin
            tick();
            chk("to.b.out", 32'(out), 32'h6);
            chk("to.b.out_valid", 32'(out_valid), 32'd1);
            chk("to.b.gnt", 32'(gnt), (i < 8) ? 32'b0010 : 32'b0001);
        end

        // drop: a leaves, b granted, b drops after one beat with d waiting
        req = 4'b0010; b = 4'h9;
        tick(); chk_all("drop.to_b", 4'b0010, 2'd1, 4'h6, 1'b0);
        tick(); chk_all("drop.beat", 4'b0010, 2'd1, 4'h9, 1'b1);
        req = 4'b1000; b = 4'h3; d = 4'hC;
        tick(); chk_all("drop.release", 4'b1000, 2'd3, 4'h9, 1'b0);
        tick(); chk_all("drop.d_beat", 4'b1000, 2'd3, 4'hC, 1'b1);

        // asynchronous reset in the middle of d's burst
        #2 rst = 1'b1;
        #1 chk_all("async_rst", 4'b0000, 2'd0, 4'h0, 1'b0);
        tick();
        rst = 1'b0; req = 4'b1001; a = 4'h7;
        tick(); chk_all("post_rst.pick", 4'b0001, 2'd0, 4'h0, 1'b0);
        tick(); chk_all("post_rst.beat", 4'b0001, 2'd0, 4'h7, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule

// File: doc/mux_4to1_rr_arbiter.md
Name: mux_4to1_rr_arbiter

Overview:
Round-robin arbiter that shares one 4:1 WIDTH-bit mux datapath between four requesters (a, b, c, d).
- Owns the mux select and registers the muxed output, with a valid strobe.
- Grants one requester at a time for a burst, ended by the requester's last, by req dropping, or by a MAX_HOLD beat timeout.
- Sits in front of any single-consumer sink that previously took a fixed-sel mux output.

Parameters:
WIDTH, 4, data width of each requester input and of out
MAX_HOLD, 8, maximum beats per grant before forced release (legal range >= 1)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  reset, asynchronous, active-high
req  input  4  request per requester; bit0=a, bit1=b, bit2=c, bit3=d
last  input  4  per-requester end-of-burst marker; meaningful only while granted and req high
a  input  WIDTH  requester 0 data
b  input  WIDTH  requester 1 data
c  input  WIDTH  requester 2 data
d  input  WIDTH  requester 3 data
sel  output  2  registered mux select (index of current/last grantee)
gnt  output  4  registered one-hot grant, 0 when idle
out  output  WIDTH  registered muxed data
out_valid  output  1  out holds a transferred beat this cycle

Behaviour:
- One clock, clk. rst is asynchronous and active-high.
- Reset values (immediate on rst=1, held until release):
  - state=IDLE, sel=0, gnt=0, out=0, out_valid=0
  - ptr=0 (priority pointer: requester ptr highest, then ptr+1.. mod 4)
  - hold_cnt=0
- IDLE:
  - If req!=0, pick the first set bit scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4).
  - At the edge: gnt<=onehot(winner), sel<=winner, hold_cnt<=0, state<=GRANT.
  - Grant latency is one cycle (req sampled at edge N, gnt visible after edge N).
  - If req==0: remain in IDLE. gnt=0, sel holds its value, out_valid<=0.
- GRANT, evaluated every edge with g=sel:
  - Beat: req[g]=1. At the edge: out<=data[g], out_valid<=1, hold_cnt<=hold_cnt+1.
  - No beat: req[g]=0. out_valid<=0, out holds, and the grant is released.
  - Release occurs on any of: req[g]=0; a beat with last[g]=1; a beat with hold_cnt==MAX_HOLD-1.
  - On release:
    - ptr<=g+1 mod 4.
    - Re-arbitrate in the same cycle over the current req using pointer g+1. The old grantee is lowest priority and may win again if it is the only requester.
    - If there is a winner: gnt/sel switch at that edge, hold_cnt<=0, stay in GRANT (no dead cycle).
    - If there is no winner: gnt<=0, state<=IDLE.
  - Otherwise the grant holds.
- MAX_HOLD=1 releases after every beat.
- hold_cnt width is ceil(log2(MAX_HOLD)), minimum 1 bit. No wrap beyond MAX_HOLD-1.
- last[i] with gnt[i]=0, or with req[i]=0, is ignored.
- out is stable whenever out_valid=0.
- sel never changes except at a new grant.
- Reset mid-burst abandons the burst: out_valid drops immediately and ptr returns to 0.
- No combinational path from inputs to outputs.

Decomposition:
- Package mux_arb_pkg:
  - state typedef (IDLE, GRANT)
  - NUM_REQ=4
  - SEL_W=2
- Sub-module rr_pick4 (combinational):
  - inputs req[3:0], ptr[1:0]
  - outputs found, idx[1:0]
  - Used for both the IDLE pick and the same-cycle re-arbitration.

Test Plan:
- Reset: assert rst mid-cycle during an active burst -> gnt=0, sel=0, out=0, out_valid=0 before the next clk edge. After release, req=4'b1001 -> requester 0 wins (ptr=0).
- Single requester: req=4'b0100, c=4'hA, last[2] on the 3rd beat -> gnt=4'b0100, sel=2 one cycle after req. out=4'hA with out_valid=1 for exactly 3 cycles. Then gnt=0, ptr=3.
- Round robin: req=4'b1111, last=4'b1111 held -> grant sequence 0,1,2,3,0,... one beat each, out_valid continuously 1, no idle cycles.
- Timeout: MAX_HOLD=8, req=4'b0011, last=0 -> requester 0 gets exactly 8 beats, then gnt=4'b0010 at the same edge. Requester 1 gets 8 beats, then requester 0 again.
- Drop: requester 1 granted, req[1] falls on its 2nd grant cycle with req[3]=1 -> only 1 beat valid, out_valid=0 the next cycle, gnt=4'b1000, out holds the last beat value.
- Idle hold: all req=0 after a grant to requester 2 -> gnt=0, sel stays 2, out unchanged, out_valid=0 indefinitely.
